serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter DIGIT, default 4: bits added per clock cycle; WIDTH SHALL be an integer multiple of DIGIT, with 1 <= DIGIT <= WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin an addition; sampled only in IDLE or DONE.
REQ-006 x  input  WIDTH  first operand, captured on the accepted start.
REQ-007 y  input  WIDTH  second operand, captured on the accepted start.
REQ-008 cin  input  1  carry-in, captured on the accepted start.
REQ-009 sum  output  WIDTH  result register.
REQ-010 carry  output  1  carry out of the MSB.
REQ-011 overflow  output  1  two's-complement overflow flag.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  one-cycle pulse when a result becomes valid.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 Transitions: IDLE->RUN on start; RUN->DONE after the last digit; DONE->RUN on start, otherwise DONE->IDLE.
REQ-016 Accepting start SHALL capture x, y and cin, clear the digit counter, and clear sum, carry and overflow to 0.
REQ-017 Each RUN cycle SHALL add digit k of x, digit k of y and the running carry, where k counts from 0 (LSB digit) upward.
REQ-018 Each RUN cycle SHALL write the DIGIT-bit result into sum[k*DIGIT +: DIGIT] and register the digit's carry-out.
REQ-019 Latency: done SHALL assert exactly WIDTH/DIGIT cycles after the accepted start edge; with default parameters that is 4 cycles.
REQ-020 In the DONE cycle, carry SHALL equal the final carry and overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-021 sum, carry and overflow SHALL hold their values until the next accepted start or reset.
REQ-022 start SHALL be ignored in RUN, and captured operands SHALL NOT change while busy.
REQ-023 start asserted during the DONE cycle SHALL be accepted, so that back-to-back operations complete with no idle gap.
REQ-024 When DIGIT == WIDTH, the block SHALL complete in 1 RUN cycle.
REQ-025 The digit counter SHALL be ceil(log2(WIDTH/DIGIT)) bits wide, minimum 1 bit, and SHALL NOT wrap within an operation.

Reset
REQ-026 On reset the FSM SHALL go to IDLE, and sum, carry, overflow, busy, done, the counter and the operand registers SHALL all be 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation, and done SHALL NOT pulse for the aborted operation.
REQ-028 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro SERIAL_ADDER_SUB_EN defined: add input sub (1 bit, captured with the operands). When sub=1 the block SHALL compute x - y as x + ~y + 1, and cin SHALL be ignored; carry SHALL then mean no-borrow.
REQ-030 Macro SERIAL_ADDER_SUB_EN undefined: the sub port SHALL be absent and the block SHALL perform addition only.

Structure
REQ-031 Package hack_arith_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH and DIGIT constants.
REQ-032 One sub-module, adder_slice, SHALL implement the DIGIT-bit combinational ripple of full adders built from half adders. It SHALL output the digit sum, the carry out of the digit, and the carry into the digit MSB.

Verification (WIDTH=16, DIGIT=4)
REQ-033 x=0x00FF, y=0x0001, cin=0 -> done on cycle 4, sum=0x0100, carry=0, overflow=0.
REQ-034 x=0xFFFF, y=0x0001, cin=0 -> sum=0x0000, carry=1, overflow=0; and x=0x7FFF, y=0x0001 -> sum=0x8000, overflow=1.
REQ-035 start re-pulsed at cycle 2 with new operands -> ignored; the original result arrives on cycle 4. Then start held during the DONE cycle -> a second done arrives 4 cycles later.
REQ-036 reset at cycle 2 of RUN -> IDLE, all outputs 0, no done pulse afterwards.
REQ-037 With SERIAL_ADDER_SUB_EN: x=5, y=7, sub=1 -> sum=0xFFFE, carry=0; x=7, y=5 -> sum=0x0002, carry=1.
REQ-038 Random regression on x, y, cin (and sub when enabled) against a reference model, repeated for DIGIT = 1, 4 and 16.

Source files
------------

// File: rtl/hack_arith_pkg.sv
// Shared types and defaults for the serial adder: FSM state encoding, default
// widths and the half-adder primitive the digit slice is built from.
package hack_arith_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {carry, sum} of two bits.
  function automatic logic [1:0] halfAdd(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational DIGIT-bit ripple adder made of full adders, each built from
// two half adders. Also exposes the carry into the digit MSB for overflow.
module adder_slice
  import hack_arith_pkg::*;
#(
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    logic [1:0] w_ha1;
    logic [1:0] w_ha2;
    assign w_ha1      = halfAdd(i_a[g], i_b[g]);
    assign w_ha2      = halfAdd(w_ha1[0], w_c[g]);
    assign o_sum[g]   = w_ha2[0];
    assign w_c[g+1]   = w_ha1[1] | w_ha2[1];
  end

  assign o_cout = w_c[DIGIT];
  assign o_cmsb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit add performed DIGIT bits per clock.
// Optional subtract mode (x + ~y + 1) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import hack_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_sum;
  logic             r_runCarry;
  logic             r_carry;
  logic             r_overflow;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_base;
  logic [WIDTH-1:0] w_xShift;
  logic [WIDTH-1:0] w_yShift;
  logic [DIGIT-1:0] w_digSum;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_yIn;
  logic             w_cinIn;

  // Subtraction is folded into the captured operand so the datapath only adds.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_yIn   = sub ? ~y : y;
  assign w_cinIn = sub | cin;
`else
  assign w_yIn   = y;
  assign w_cinIn = cin;
`endif

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_cnt == CW'(NDIG - 1));
  assign w_base   = 32'(r_cnt) * 32'(DIGIT);
  assign w_xShift = r_x >> w_base;
  assign w_yShift = r_y >> w_base;

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .i_a    (w_xShift[DIGIT-1:0]),
    .i_b    (w_yShift[DIGIT-1:0]),
    .i_cin  (r_runCarry),
    .o_sum  (w_digSum),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  // The running carry is internal; the visible carry/overflow only update on the last digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_sum      <= '0;
      r_runCarry <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_x        <= x;
      r_y        <= w_yIn;
      r_runCarry <= w_cinIn;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_cnt      <= '0;
    end else if (r_state == RUN) begin
      r_sum[w_base +: DIGIT] <= w_digSum;
      r_runCarry             <= w_cout;
      if (w_last) begin
        r_carry    <= w_cout;
        r_overflow <= w_cmsb ^ w_cout;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sum      = r_sum;
  assign carry    = r_carry;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (default build, SERIAL_ADDER_SUB_EN undefined):
// three instances with DIGIT = 1, 4 and 16 checked through per-instance result queues.
module tb_serial_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
  } res_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    res_t        exp;
  } vector_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start4, start16;
  logic [15:0] x, y;
  logic        cin;
  logic [15:0] sum1, sum4, sum16;
  logic        carry1, carry4, carry16;
  logic        ovf1, ovf4, ovf16;
  logic        busy1, busy4, busy16;
  logic        done1, done4, done16;

  res_t q1[$];
  res_t q4[$];
  res_t q16[$];

  int nPass   = 0;
  int nChecks = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .x(x), .y(y), .cin(cin),
    .sum(sum1), .carry(carry1), .overflow(ovf1), .busy(busy1), .done(done1)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .x(x), .y(y), .cin(cin),
    .sum(sum4), .carry(carry4), .overflow(ovf4), .busy(busy4), .done(done4)
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .x(x), .y(y), .cin(cin),
    .sum(sum16), .carry(carry16), .overflow(ovf16), .busy(busy16), .done(done16)
  );

  // Reference: plain wide addition; overflow from operand/result sign bits.
  function automatic res_t refAdd(input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [16:0] t;
    res_t r;
    t   = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    r.s = t[15:0];
    r.c = t[16];
    r.v = (a[15] == b[15]) && (t[15] != a[15]);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
  endtask

  task automatic checkResult(input string name, input logic [15:0] s, input logic c,
                             input logic v, input res_t e);
    checkOutput({name, " sum"}, 32'(s), 32'(e.s));
    checkOutput({name, " carry"}, 32'(c), 32'(e.c));
    checkOutput({name, " overflow"}, 32'(v), 32'(e.v));
  endtask

  // Scoreboard monitors: every done pulse pops the oldest expected result.
  always @(negedge clk) begin
    res_t e;
    if (done1) begin
      if (q1.size() == 0) checkOutput("dut1 unexpected done", 32'd1, 32'd0);
      else begin e = q1.pop_front(); checkResult("dut1", sum1, carry1, ovf1, e); end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (done4) begin
      if (q4.size() == 0) checkOutput("dut4 unexpected done", 32'd1, 32'd0);
      else begin e = q4.pop_front(); checkResult("dut4", sum4, carry4, ovf4, e); end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (done16) begin
      if (q16.size() == 0) checkOutput("dut16 unexpected done", 32'd1, 32'd0);
      else begin e = q16.pop_front(); checkResult("dut16", sum16, carry16, ovf16, e); end
    end
  end

  task automatic waitDone(output int cyc);
    cyc = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done4) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] ax, input logic [15:0] ay,
                               input logic acin, input res_t e);
    int c;
    @(negedge clk);
    start4 = 1'b1; x = ax; y = ay; cin = acin;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
    waitDone(c);
    checkOutput("latency4", 32'(c), 32'd4);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vector_t vecs[9];
    int      c, lat1, lat4, lat16;
    res_t    e;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, '{16'h0100, 1'b0, 1'b0}};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, '{16'h0001, 1'b0, 1'b0}};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0}};
    vecs[6] = '{16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0}};
    vecs[7] = '{16'h0FFF, 16'h0000, 1'b1, '{16'h1000, 1'b0, 1'b0}};
    vecs[8] = '{16'h7FFF, 16'h7FFF, 1'b1, '{16'hFFFF, 1'b0, 1'b1}};

    reset = 1'b1; start1 = 1'b0; start4 = 1'b0; start16 = 1'b0;
    x = '0; y = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset sum", 32'(sum4), 32'd0);
    checkOutput("reset carry", 32'(carry4), 32'd0);
    checkOutput("reset overflow", 32'(ovf4), 32'd0);
    checkOutput("reset busy", 32'(busy4), 32'd0);
    checkOutput("reset done", 32'(done4), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].exp);

    // Result must hold after the operation returns to IDLE.
    repeat (3) @(negedge clk);
    checkResult("hold", sum4, carry4, ovf4, vecs[8].exp);
    checkOutput("hold busy", 32'(busy4), 32'd0);

    // Start during RUN is ignored; start during DONE chains with no gap.
    @(negedge clk);
    start4 = 1'b1; x = 16'h1111; y = 16'h2222; cin = 1'b0;
    q4.push_back('{16'h3333, 1'b0, 1'b0});
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; x = 16'hAAAA; y = 16'h5555; cin = 1'b1;
    @(negedge clk);
    start4 = 1'b0; x = '0; y = '0; cin = 1'b0;
    waitDone(c);
    checkOutput("ignored start latency", 32'(2 + c), 32'd4);
    start4 = 1'b1; x = 16'h0F0F; y = 16'h00F1; cin = 1'b0;
    q4.push_back('{16'h1000, 1'b0, 1'b0});
    @(negedge clk);
    start4 = 1'b0;
    checkOutput("b2b busy", 32'(busy4), 32'd1);
    waitDone(c);
    checkOutput("b2b latency", 32'(c), 32'd4);

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    start4 = 1'b1; x = 16'h1234; y = 16'h1111; cin = 1'b1;
    q4.push_back('{16'h2346, 1'b0, 1'b0});
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    q4.delete();
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort sum", 32'(sum4), 32'd0);
    checkOutput("abort carry", 32'(carry4), 32'd0);
    checkOutput("abort overflow", 32'(ovf4), 32'd0);
    checkOutput("abort busy", 32'(busy4), 32'd0);
    c = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4) c++;
    end
    checkOutput("abort no done", 32'(c), 32'd0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset = 1'b1; start4 = 1'b1; x = 16'h0001; y = 16'h0001;
    @(negedge clk);
    reset = 1'b0; start4 = 1'b0;
    checkOutput("reset priority busy", 32'(busy4), 32'd0);
    @(negedge clk);
    checkOutput("reset priority idle", 32'(busy4), 32'd0);

    // Random regression across DIGIT = 1, 4 and 16.
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      x   = (n % 7 == 0) ? 16'hFFFF : 16'($urandom);
      y   = (n % 5 == 0) ? 16'h8000 : 16'($urandom);
      cin = 1'($urandom);
      e   = refAdd(x, y, cin);
      q1.push_back(e); q4.push_back(e); q16.push_back(e);
      start1 = 1'b1; start4 = 1'b1; start16 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0; start16 = 1'b0;
      lat1 = 0; lat4 = 0; lat16 = 0;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (done1  && lat1  == 0) lat1  = i;
        if (done4  && lat4  == 0) lat4  = i;
        if (done16 && lat16 == 0) lat16 = i;
        if (lat1 != 0 && lat4 != 0 && lat16 != 0) break;
      end
      checkOutput("rand latency1", 32'(lat1), 32'd16);
      checkOutput("rand latency4", 32'(lat4), 32'd4);
      checkOutput("rand latency16", 32'(lat16), 32'd1);
    end

    repeat (2) @(negedge clk);
    checkOutput("queue1 drained", 32'(q1.size()), 32'd0);
    checkOutput("queue4 drained", 32'(q4.size()), 32'd0);
    checkOutput("queue16 drained", 32'(q16.size()), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
